// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares the single-ported instruction memory between the instruction-fetch
// stage and the program loader / debug port.
//
//   * Fetch has priority in the shared (IDLE) state.
//   * A starvation counter forces one loader beat through after STARVE_LIMIT
//     consecutive fetch grants that blocked a waiting loader.
//   * A lock mode (LOCK) gives the loader uninterrupted burst ownership for
//     program download. Ownership ends on the first cycle with l_lock low.
//     That cycle's loader beat, if there is one, is still granted.
//   * fetch_stall tells the fetch stage to hold its PC while it is not granted.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   f_req/f_addr       fetch read request and PC
//   f_kill             cancels the response of the fetch granted this cycle
//   f_gnt              fetch granted this cycle (combinational)
//   f_rvalid/f_rdata   fetch response, one cycle after the grant
//   fetch_stall        f_req & ~f_gnt
//   l_req/l_we/l_lock  loader request, write select, lock request
//   l_addr/l_wdata     loader address and write data
//   l_gnt              loader granted this cycle (combinational)
//   l_rvalid/l_rdata   loader read response, one cycle after the grant
//   mem_*              memory port. mem_rdata is valid one cycle after a read.
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    input  logic                  f_kill,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    output logic                  fetch_stall,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic                  l_lock,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Owner of the read issued in the previous cycle.
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_LOAD  = 2'd2
    } tag_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] starve_r;
    logic [CNT_W-1:0] starve_s;
    tag_t             tag_r;
    tag_t             tag_s;
    logic             f_gnt_s;
    logic             l_gnt_s;

    // Grant decision and next ownership state.
    always_comb begin
        f_gnt_s = 1'b0;
        l_gnt_s = 1'b0;
        state_s = state_r;
        if (rst) begin
            // No grants while reset is asserted.
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (f_req && l_req) begin
                        // The loader wins a contested cycle only once it has
                        // been blocked STARVE_LIMIT times in a row.
                        if (starve_r == STARVE_MAX) begin
                            l_gnt_s = 1'b1;
                        end else begin
                            f_gnt_s = 1'b1;
                        end
                    end else begin
                        f_gnt_s = f_req;
                        l_gnt_s = l_req;
                    end
                    if (l_gnt_s && l_lock) begin
                        state_s = ST_LOCK;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    l_gnt_s = l_req;
                    // Lock is released by l_lock=0 even when no beat is present.
                    if (!l_lock) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_LOCK;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Starvation counter update. Saturates, never wraps.
    always_comb begin
        starve_s = starve_r;
        if (l_gnt_s || !l_req) begin
            starve_s = '0;
        end else if (f_gnt_s && (starve_r != STARVE_MAX)) begin
            starve_s = starve_r + CNT_W'(1);
        end else begin
            starve_s = starve_r;
        end
    end

    // Response tag. Killed fetches and loader writes expect no data.
    always_comb begin
        tag_s = TAG_NONE;
        if (f_gnt_s && !f_kill) begin
            tag_s = TAG_FETCH;
        end else if (l_gnt_s && !l_we) begin
            tag_s = TAG_LOAD;
        end else begin
            tag_s = TAG_NONE;
        end
    end

    // State, counter and tag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            starve_r <= '0;
            tag_r    <= TAG_NONE;
        end else begin
            state_r  <= state_s;
            starve_r <= starve_s;
            tag_r    <= tag_s;
        end
    end

    // Memory port mux. The bus stays at zero when no requester is granted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt_s) begin
            mem_addr = f_addr;
        end else if (l_gnt_s) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end else begin
            mem_we    = 1'b0;
        end
    end

    assign mem_en      = f_gnt_s | l_gnt_s;
    assign f_gnt       = f_gnt_s;
    assign l_gnt       = l_gnt_s;
    assign fetch_stall = f_req & ~f_gnt_s;

    // A response in flight when reset arrives is dropped.
    assign f_rvalid = (tag_r == TAG_FETCH) & ~rst;
    assign l_rvalid = (tag_r == TAG_LOAD) & ~rst;
    assign f_rdata  = mem_rdata;
    assign l_rdata  = mem_rdata;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter sharing the single-ported instruction memory between the instruction-fetch stage and the program loader/debug port. Fetch has priority. A starvation counter guarantees loader progress, and a lock mode gives the loader uninterrupted burst access for program download. The block drives the fetch stall so the fetch stage holds its PC while it does not own the memory.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width of both requesters and memory
- DATA_WIDTH, 32, memory word width
- STARVE_LIMIT, 4, consecutive loader-blocking fetch grants before the loader is forced through (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- f_req  in  1  fetch read request
- f_addr  in  ADDR_WIDTH  fetch address (the PC)
- f_kill  in  1  branch redirect; cancels the response of the fetch granted this cycle
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_WIDTH  fetch read data
- fetch_stall  out  1  f_req & ~f_gnt
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_lock  in  1  loader requests exclusive ownership after this grant
- l_addr  in  ADDR_WIDTH  loader address
- l_wdata  in  DATA_WIDTH  loader write data
- l_gnt  out  1  loader granted this cycle (combinational)
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DATA_WIDTH  loader read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- States: IDLE (shared) and LOCK (loader owns memory).
- IDLE, grant rules:
  - Only f_req → fetch granted.
  - Only l_req → loader granted.
  - Both, starve_cnt < STARVE_LIMIT → fetch granted.
  - Both, starve_cnt == STARVE_LIMIT → loader granted.
- LOCK: f_gnt=0 always. l_gnt=l_req.
- Transitions:
  - IDLE→LOCK when the loader is granted with l_lock=1.
  - LOCK→IDLE on any cycle with l_lock=0, whether granted or not. That cycle's loader beat, if any, is still granted.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when fetch is granted while l_req=1.
  - Clears when the loader is granted or l_req=0.
- Memory drive:
  - mem_en = f_gnt|l_gnt.
  - Address, write data and we are muxed from the granted requester; fetch forces mem_we=0.
  - With no grant: mem_addr and mem_wdata are 0, mem_we=0.
- Response tracking:
  - One registered tag records the owner of a read issued this cycle: fetch, loader, or none.
  - Loader writes and killed fetches record none.
- Responses:
  - f_rvalid/l_rvalid assert one cycle after the corresponding read grant.
  - f_rdata and l_rdata both carry mem_rdata unconditionally; only rvalid is gated.
- f_kill with no fetch grant in the same cycle has no effect.
- fetch_stall is high in LOCK whenever f_req=1.

## Timing
- Reset values: state=IDLE, starve_cnt=0, response tag=none.
  - Hence f_rvalid=l_rvalid=0 in the cycle after reset.
  - Grants and mem_en are 0 while rst=1.
- Grant-to-data latency is 1 cycle, at full throughput: a new grant is possible every cycle, back-to-back.
- Reset in LOCK returns to IDLE. Any in-flight response is dropped.
- Simultaneous f_kill and a fetch grant: the memory read is still issued, and f_rvalid is 0 next cycle.
- starve_cnt saturates at STARVE_LIMIT and never wraps.

## Test plan
- f_req=1 for 3 cycles, addr 0x0/0x4/0x8, l_req=0 → f_gnt=1 each cycle, f_rvalid=1 in cycles 2–4 with mem_rdata, fetch_stall=0.
- f_req and l_req both held high, STARVE_LIMIT=4 → fetch granted 4 cycles, loader granted on the 5th (fetch_stall=1 that cycle), counter clears, then fetch granted again.
- Loader writes 0x10, 0x14, 0x18 with l_lock=1,1,0 while f_req=1 → fetch blocked for all three beats, mem_we=1 throughout, no l_rvalid, f_gnt resumes the cycle after the l_lock=0 beat.
- Fetch at 0x20 granted with f_kill=1 → mem_en=1 and mem_addr=0x20, f_rvalid=0 next cycle; a following unkilled fetch at 0x24 returns f_rvalid=1.
- rst asserted in LOCK with a loader read outstanding → next cycle l_rvalid=0, state IDLE, and f_req alone is granted immediately after rst deasserts.
